undo_log_writer: RTL

UNDO_LOG_WRITER -- requirements
Module: undo_log_writer

---
 rtl/swarm_pkg.sv | 25 ++
 rtl/undo_log_fifo.sv | 47 ++++
 rtl/undo_log_writer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/swarm_pkg.sv
// Shared undo-log entry types and the slot address helper for the undo log writer.
package swarm;

    localparam int UNDO_LOG_ADDR_WIDTH = 32;
    localparam int UNDO_LOG_DATA_WIDTH = 32;

    typedef logic [UNDO_LOG_ADDR_WIDTH-1:0] undo_log_addr_t;
    typedef logic [UNDO_LOG_DATA_WIDTH-1:0] undo_log_data_t;

    typedef struct packed {
        undo_log_data_t data;
        undo_log_addr_t addr;
    } undo_log_entry_t;

    localparam logic [7:0] UNDO_LOG_AWLEN  = 8'd1;
    localparam logic [2:0] UNDO_LOG_AWSIZE = 3'b010;
    localparam logic [3:0] UNDO_LOG_WSTRB  = 4'b1111;

    // Each slot holds one {addr, data} pair, i.e. 8 bytes; wraps modulo 2^32.
    function automatic logic [31:0] undo_log_slot_addr(input logic [31:0] base,
                                                       input logic [31:0] slot);
        return base + (slot << 3);
    endfunction

endpackage

// File: rtl/undo_log_fifo.sv
// Synchronous entry FIFO for the undo log writer; DEPTH must be a power of two.
module undo_log_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] occ_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [OW-1:0]    occ_q;

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_i && !pop_i)      occ_q <= occ_q + OW'(1);
            else if (pop_i && !push_i) occ_q <= occ_q - OW'(1);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (occ_q == OW'(DEPTH));
    assign empty_o = (occ_q == '0);
    assign occ_o   = occ_q;

endmodule

// File: rtl/undo_log_writer.sv
// Buffers {data,addr} undo entries and writes each as a 2-beat AXI burst into the task's log region.
// Optional UNDO_LOG_COALESCE_EN drops an entry whose addr repeats the last accepted addr.
//   state | meaning
//   IDLE  | no write in flight, waiting for a buffered entry
//   BEAT0 | AW plus first W beat (entry addr), handshakes tracked separately
//   BEAT1 | second W beat (entry data, WLAST)
//   RESP  | waiting for B; pop and count on BVALID
module undo_log_writer
    import swarm::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_ENTRIES = 16
) (
    input  logic                                           clk,
    input  logic                                           rstn,
    input  logic                                           task_start,
    input  logic [31:0]                                    log_base,
    input  logic [UNDO_LOG_ADDR_WIDTH+UNDO_LOG_DATA_WIDTH-1:0] entry_in,
    input  logic                                           entry_vld,
    output logic                                           entry_rdy,
    output logic                                           AWVALID,
    input  logic                                           AWREADY,
    output logic [31:0]                                    AWADDR,
    output logic [7:0]                                     AWLEN,
    output logic [2:0]                                     AWSIZE,
    output logic                                           WVALID,
    input  logic                                           WREADY,
    output logic [31:0]                                    WDATA,
    output logic [3:0]                                     WSTRB,
    output logic                                           WLAST,
    input  logic                                           BVALID,
    output logic                                           BREADY,
    input  logic [1:0]                                     BRESP,
    output logic [$clog2(MAX_ENTRIES+1)-1:0]               log_count,
    output logic                                           busy,
    output logic                                           overflow,
    output logic                                           resp_err
);

    localparam int CW = $clog2(MAX_ENTRIES+1);
    localparam int OW = $clog2(FIFO_DEPTH+1);
    localparam int EW = UNDO_LOG_ADDR_WIDTH + UNDO_LOG_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} wr_state_e;

    wr_state_e       state_q;
    logic [31:0]     log_base_q;
    logic [CW-1:0]   log_count_q;
    logic            overflow_q, resp_err_q;
    logic            awvalid_q, wvalid_q, wlast_q, bready_q;
    logic [31:0]     awaddr_q, wdata_q;
    logic [7:0]      awlen_q;
    logic [2:0]      awsize_q;
    logic [3:0]      wstrb_q;

    logic [EW-1:0]   fifo_rdata;
    undo_log_entry_t head;
    logic            fifo_full, fifo_empty;
    logic [OW-1:0]   fifo_occ;
    logic            start_ok, slot_ok, coal_hit, accept, push, pop;
    logic [31:0]     base_eff;
    logic [CW-1:0]   count_eff;

    assign head      = fifo_rdata;
    assign busy      = !fifo_empty || (state_q != IDLE);
    assign start_ok  = task_start && !busy;
    // The entry being written stays in the FIFO until its B response, so occupancy covers it.
    assign slot_ok   = (32'(log_count_q) + 32'(fifo_occ)) < 32'(MAX_ENTRIES);
    assign entry_rdy = coal_hit || (!fifo_full && slot_ok);
    assign accept    = entry_vld && entry_rdy;
    assign push      = accept && !coal_hit;
    assign pop       = (state_q == RESP) && BVALID;
    assign base_eff  = start_ok ? log_base : log_base_q;
    assign count_eff = start_ok ? '0 : log_count_q;

`ifdef UNDO_LOG_COALESCE_EN
    undo_log_addr_t last_addr_q;
    logic           last_vld_q;

    assign coal_hit = last_vld_q && !start_ok &&
                      (entry_in[UNDO_LOG_ADDR_WIDTH-1:0] == last_addr_q);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_vld_q  <= 1'b0;
            last_addr_q <= '0;
        end else if (accept) begin
            last_vld_q  <= 1'b1;
            last_addr_q <= entry_in[UNDO_LOG_ADDR_WIDTH-1:0];
        end else if (start_ok) begin
            last_vld_q  <= 1'b0;
        end
    end
`else
    assign coal_hit = 1'b0;
`endif

    undo_log_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (entry_in),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .occ_o   (fifo_occ)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            log_base_q  <= '0;
            log_count_q <= '0;
            overflow_q  <= 1'b0;
            resp_err_q  <= 1'b0;
        end else if (start_ok) begin
            log_base_q  <= log_base;
            log_count_q <= '0;
            overflow_q  <= 1'b0;
            resp_err_q  <= 1'b0;
        end else begin
            if (pop) begin
                log_count_q <= log_count_q + CW'(1);
                if (BRESP != 2'b00) resp_err_q <= 1'b1;
            end
            // A FIFO-full stall is back-pressure, not a lost slot.
            if (entry_vld && !fifo_full && !slot_ok && !coal_hit) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awsize_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wlast_q   <= 1'b0;
            bready_q  <= 1'b0;
        end else begin
            awlen_q  <= UNDO_LOG_AWLEN;
            awsize_q <= UNDO_LOG_AWSIZE;
            wstrb_q  <= UNDO_LOG_WSTRB;
            case (state_q)
                IDLE: begin
                    // Launch on the push itself so AW follows acceptance by one cycle.
                    if (!fifo_empty || push) begin
                        state_q   <= BEAT0;
                        awvalid_q <= 1'b1;
                        awaddr_q  <= undo_log_slot_addr(base_eff, 32'(count_eff));
                        wvalid_q  <= 1'b1;
                        wdata_q   <= fifo_empty ? entry_in[UNDO_LOG_ADDR_WIDTH-1:0] : head.addr;
                        wlast_q   <= 1'b0;
                    end
                end
                BEAT0: begin
                    if (awvalid_q && AWREADY) awvalid_q <= 1'b0;
                    if (wvalid_q && WREADY)   wvalid_q  <= 1'b0;
                    if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) begin
                        state_q  <= BEAT1;
                        wvalid_q <= 1'b1;
                        wdata_q  <= head.data;
                        wlast_q  <= 1'b1;
                    end
                end
                BEAT1: begin
                    if (WREADY) begin
                        state_q  <= RESP;
                        wvalid_q <= 1'b0;
                        wlast_q  <= 1'b0;
                        bready_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (BVALID) begin
                        state_q  <= IDLE;
                        bready_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign AWVALID   = awvalid_q;
    assign AWADDR    = awaddr_q;
    assign AWLEN     = awlen_q;
    assign AWSIZE    = awsize_q;
    assign WVALID    = wvalid_q;
    assign WDATA     = wdata_q;
    assign WSTRB     = wstrb_q;
    assign WLAST     = wlast_q;
    assign BREADY    = bready_q;
    assign log_count = log_count_q;
    assign overflow  = overflow_q;
    assign resp_err  = resp_err_q;

endmodule
